// File: rtl/rv_ctrl_id_pkg.sv
// Shared decode definitions for the ID-stage control unit: opcodes, ALU1 source
// encodings and the control bundle carried into the ID/EX register.
package rv_ctrl_id_pkg;

    localparam int unsigned OPC_W  = 7;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned ALU1_W = 2;

    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_R32    = 7'b0111011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_IMM32  = 7'b0011011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ALU1_W-1:0] ALU1_RS1  = 2'b00;
    localparam logic [ALU1_W-1:0] ALU1_ZERO = 2'b01;
    localparam logic [ALU1_W-1:0] ALU1_PC   = 2'b10;

    typedef struct packed {
        logic              branch;
        logic              mem_read;
        logic              mem_to_reg;
        logic              mem_write;
        logic              alu2_src;
        logic              reg_write;
        logic              jal;
        logic              jalr;
        logic [ALU1_W-1:0] alu1_src;
        logic [1:0]        reg_read;
        logic              illegal;
    } ctrl_t;

endpackage

// File: rtl/rv_ctrl_dec.sv
// Combinational opcode-to-control-bundle decoder; unknown opcodes (which include any
// word with instr[1:0] != 11) and, on RV32, the 32b-word opcodes flag illegal.
module rv_ctrl_dec
    import rv_ctrl_id_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl
);

    localparam bit RV64 = (XLEN == 64);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_R: begin
                ctrl.reg_read  = 2'b11;
                ctrl.reg_write = 1'b1;
            end
            OP_R32: begin
                ctrl.reg_read  = RV64 ? 2'b11 : 2'b00;
                ctrl.reg_write = RV64;
                ctrl.illegal   = !RV64;
            end
            OP_IMM: begin
                ctrl.alu2_src  = 1'b1;
                ctrl.reg_read  = 2'b01;
                ctrl.reg_write = 1'b1;
            end
            OP_IMM32: begin
                ctrl.alu2_src  = RV64;
                ctrl.reg_read  = RV64 ? 2'b01 : 2'b00;
                ctrl.reg_write = RV64;
                ctrl.illegal   = !RV64;
            end
            OP_LOAD: begin
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu2_src   = 1'b1;
                ctrl.reg_read   = 2'b01;
                ctrl.reg_write  = 1'b1;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu2_src  = 1'b1;
                ctrl.reg_read  = 2'b11;
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.reg_read = 2'b11;
            end
            OP_JAL: begin
                ctrl.branch    = 1'b1;
                ctrl.jal       = 1'b1;
                ctrl.alu1_src  = ALU1_PC;
                ctrl.alu2_src  = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_LUI: begin
                ctrl.alu1_src  = ALU1_ZERO;
                ctrl.alu2_src  = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.alu1_src  = ALU1_PC;
                ctrl.alu2_src  = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_JALR: begin
                ctrl.branch    = 1'b1;
                ctrl.jalr      = 1'b1;
                ctrl.alu1_src  = ALU1_PC;
                ctrl.alu2_src  = 1'b1;
                ctrl.reg_read  = 2'b01;
                ctrl.reg_write = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv_ctrl_id.sv
// ID-stage control unit: decodes the instruction into the ID/EX register behind a
// valid/ready handshake, with load-use bubble insertion, flush and a stall counter.
module rv_ctrl_id
    import rv_ctrl_id_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr_i,
    input  logic             flush_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             branch_o,
    output logic             mem_read_o,
    output logic             mem_to_reg_o,
    output logic             mem_write_o,
    output logic             alu2_src_o,
    output logic             reg_write_o,
    output logic             jal_o,
    output logic             jalr_o,
    output logic [1:0]       alu1_src_o,
    output logic [1:0]       reg_read_o,
    output logic             illegal_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [4:0]       rd_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    ctrl_t            dec_c;
    ctrl_t            ctrl_q;
    logic [REG_W-1:0] rs1_q, rs2_q, rd_q;
    logic [CNT_W-1:0] stall_q;
    logic             valid_q;
    logic             adv, haz, hit_rs1, hit_rs2;
    logic             unused_instr_bits;

    rv_ctrl_dec #(.XLEN(XLEN)) u_dec (
        .opcode (instr_i[OPC_W-1:0]),
        .ctrl   (dec_c)
    );

    assign unused_instr_bits = ^{instr_i[31:25], instr_i[14:12]};

    // Load-use hazard against the load currently sitting in ID/EX; x0 never conflicts.
    assign adv      = !valid_q || out_ready;
    assign hit_rs1  = dec_c.reg_read[0] && (instr_i[19:15] == rd_q);
    assign hit_rs2  = dec_c.reg_read[1] && (instr_i[24:20] == rd_q);
    assign haz      = in_valid && valid_q && ctrl_q.mem_read && (rd_q != '0) && (hit_rs1 || hit_rs2);
    assign in_ready = flush_i || (adv && !haz);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            stall_q <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else if (adv && haz) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            if (stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end else if (adv && in_valid) begin
            valid_q <= 1'b1;
            ctrl_q  <= dec_c;
            rs1_q   <= instr_i[19:15];
            rs2_q   <= instr_i[24:20];
            rd_q    <= instr_i[11:7];
        end else if (adv) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid    = valid_q;
    assign branch_o     = ctrl_q.branch;
    assign mem_read_o   = ctrl_q.mem_read;
    assign mem_to_reg_o = ctrl_q.mem_to_reg;
    assign mem_write_o  = ctrl_q.mem_write;
    assign alu2_src_o   = ctrl_q.alu2_src;
    assign reg_write_o  = ctrl_q.reg_write;
    assign jal_o        = ctrl_q.jal;
    assign jalr_o       = ctrl_q.jalr;
    assign alu1_src_o   = ctrl_q.alu1_src;
    assign reg_read_o   = ctrl_q.reg_read;
    assign illegal_o    = ctrl_q.illegal;
    assign rs1_o        = rs1_q;
    assign rs2_o        = rs2_q;
    assign rd_o         = rd_q;
    assign stall_cnt_o  = stall_q;

endmodule
